mca_acq_sequencer: RTL and testbench



---
 rtl/mca_acq_sequencer.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_mca_acq_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mca_acq_sequencer.sv
// rtl/mca_acq_sequencer.sv - MCA histogram sequencer: clear, event acquisition, peak-search scan
//
// Optional feature macro: MCA_SMOOTH_EN (7-tap summed metric for the peak search)
//
// Ports:
//   clk, rst                    single clock, synchronous active-high reset
//   start, stop                 begin measurement (IDLE/DONE) / end acquisition early (ACQ)
//   target_events, peak_thr     event limit (0 = until stop) and peak threshold, sampled at start
//   ev_valid, ev_chan, ev_ready event stream (channel number per event)
//   ram_addr, ram_we,
//   ram_wdata, ram_rdata        single-port synchronous histogram RAM, 1-cycle read latency
//   peak_valid, peak_chan,
//   peak_ready                  peak channel stream to the host
//   busy, done                  status (CLEAR/ACQ/SCAN, DONE)
//   event_cnt, peak_cnt         events accepted, peaks emitted
module mca_acq_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic [31:0] target_events,
   input  logic [15:0] peak_thr,
   input  logic        ev_valid,
   input  logic [9:0]  ev_chan,
   output logic        ev_ready,
   output logic [9:0]  ram_addr,
   output logic        ram_we,
   output logic [15:0] ram_wdata,
   input  logic [15:0] ram_rdata,
   output logic        peak_valid,
   output logic [9:0]  peak_chan,
   input  logic        peak_ready,
   output logic        busy,
   output logic        done,
   output logic [31:0] event_cnt,
   output logic [10:0] peak_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_ACQ_RD, S_ACQ_WR, S_SCAN, S_DONE
   } state_t;

   localparam logic [9:0] LAST_ADDR = 10'd1023;

   state_t      state_q, state_d;
   logic [9:0]  addr_q, addr_d;
   logic [31:0] tgt_q, tgt_d;
   logic [15:0] thr_q, thr_d;
   logic [31:0] event_cnt_q, event_cnt_d;
   logic [10:0] peak_cnt_q, peak_cnt_d;
   logic        stop_pend_q, stop_pend_d;
   // scan pipeline: rv_q = RAM data for ridx_q arrives this cycle,
   // hold_* = that data parked while the peak output is stalled
   logic        issue_done_q, issue_done_d;
   logic        rv_q, rv_d;
   logic [9:0]  ridx_q, ridx_d;
   logic        hold_v_q, hold_v_d;
   logic [15:0] hold_q, hold_d;
   logic        peak_valid_q, peak_valid_d;
   logic [9:0]  peak_chan_q, peak_chan_d;
`ifdef MCA_SMOOTH_EN
   logic [15:0] tap_q [0:6];
   logic [15:0] tap_d [0:6];
   logic [18:0] sum_q, sum_d;
   logic [18:0] s1_q, s1_d;
   logic [18:0] s2_q, s2_d;
   logic [18:0] thr7;
   logic [18:0] sum_new;
`else
   logic [15:0] w1_q, w1_d;
   logic [15:0] w2_q, w2_d;
`endif

   logic        stall;
   logic        data_avail;
   logic [15:0] data;
   logic        is_peak;
   logic [9:0]  cand_chan;
   logic        enter_scan;

   assign ev_ready   = (state_q == S_ACQ_RD);
   // the read address must follow ev_chan in the same cycle the event is accepted
   assign ram_addr   = (state_q == S_ACQ_RD) ? ev_chan : addr_q;
   assign ram_we     = (state_q == S_CLEAR) || (state_q == S_ACQ_WR);
   assign ram_wdata  = (state_q != S_ACQ_WR) ? 16'd0 :
                       (ram_rdata == 16'hFFFF) ? 16'hFFFF : ram_rdata + 16'd1;
   assign busy       = (state_q == S_CLEAR) || (state_q == S_ACQ_RD) ||
                       (state_q == S_ACQ_WR) || (state_q == S_SCAN);
   assign done       = (state_q == S_DONE);
   assign event_cnt  = event_cnt_q;
   assign peak_cnt   = peak_cnt_q;
   assign peak_valid = peak_valid_q;
   assign peak_chan  = peak_chan_q;

   assign stall      = peak_valid_q && !peak_ready;
   assign data_avail = rv_q || hold_v_q;
   assign data       = hold_v_q ? hold_q : ram_rdata;

   // Peak test on the newest sample: the centre lags the newest bin by 1 (raw)
   // or by 4 (3 bins of window half-width plus one bin of look-ahead).
`ifdef MCA_SMOOTH_EN
   assign thr7      = ({3'd0, thr_q} << 3) - {3'd0, thr_q};
   assign sum_new   = sum_q + {3'd0, data} - {3'd0, tap_q[6]};
   assign is_peak   = (ridx_q >= 10'd8) && (s1_q > s2_q) && (s1_q > sum_new) && (s1_q > thr7);
   assign cand_chan = ridx_q - 10'd4;
`else
   assign is_peak   = (ridx_q >= 10'd2) && (w1_q > w2_q) && (w1_q > data) && (w1_q > thr_q);
   assign cand_chan = ridx_q - 10'd1;
`endif

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      tgt_d        = tgt_q;
      thr_d        = thr_q;
      event_cnt_d  = event_cnt_q;
      peak_cnt_d   = peak_cnt_q;
      stop_pend_d  = stop_pend_q;
      issue_done_d = issue_done_q;
      rv_d         = rv_q;
      ridx_d       = ridx_q;
      hold_v_d     = hold_v_q;
      hold_d       = hold_q;
      peak_valid_d = peak_valid_q;
      peak_chan_d  = peak_chan_q;
      enter_scan   = 1'b0;
`ifdef MCA_SMOOTH_EN
      for (int k = 0; k < 7; k++) tap_d[k] = tap_q[k];
      sum_d = sum_q;
      s1_d  = s1_q;
      s2_d  = s2_q;
`else
      w1_d = w1_q;
      w2_d = w2_q;
`endif

      if (peak_valid_q && peak_ready) begin
         peak_valid_d = 1'b0;
         peak_cnt_d   = peak_cnt_q + 11'd1;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d     = S_CLEAR;
               addr_d      = 10'd0;
               tgt_d       = target_events;
               thr_d       = peak_thr;
               event_cnt_d = 32'd0;
               peak_cnt_d  = 11'd0;
               stop_pend_d = 1'b0;
            end
         end
         S_CLEAR: begin
            addr_d = addr_q + 10'd1;
            if (addr_q == LAST_ADDR) state_d = S_ACQ_RD;
         end
         S_ACQ_RD: begin
            if (ev_valid) begin
               addr_d      = ev_chan;
               event_cnt_d = event_cnt_q + 32'd1;
               stop_pend_d = stop;
               state_d     = S_ACQ_WR;
            end else if (stop) begin
               enter_scan = 1'b1;
            end
         end
         S_ACQ_WR: begin
            if (stop_pend_q || ((tgt_q != 32'd0) && (event_cnt_q == tgt_q)))
               enter_scan = 1'b1;
            else
               state_d = S_ACQ_RD;
         end
         S_SCAN: begin
            if (!stall) begin
               rv_d     = !issue_done_q;
               ridx_d   = addr_q;
               hold_v_d = 1'b0;
               if (!issue_done_q) begin
                  if (addr_q == LAST_ADDR) issue_done_d = 1'b1;
                  else                     addr_d = addr_q + 10'd1;
               end
               if (data_avail) begin
                  if (is_peak) begin
                     peak_valid_d = 1'b1;
                     peak_chan_d  = cand_chan;
                  end
`ifdef MCA_SMOOTH_EN
                  tap_d[0] = data;
                  for (int k = 1; k < 7; k++) tap_d[k] = tap_q[k-1];
                  sum_d = sum_new;
                  s1_d  = sum_new;
                  s2_d  = s1_q;
`else
                  w1_d = data;
                  w2_d = w1_q;
`endif
               end
            end else begin
               // address is frozen, so the RAM output is only meaningful the
               // first stalled cycle after an issue: park it
               rv_d = 1'b0;
               if (rv_q) begin
                  hold_d   = ram_rdata;
                  hold_v_d = 1'b1;
               end
            end
            if (issue_done_q && !rv_q && !hold_v_q && (!peak_valid_q || peak_ready)) begin
               state_d      = S_DONE;
               peak_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (enter_scan) begin
         state_d      = S_SCAN;
         addr_d       = 10'd0;
         issue_done_d = 1'b0;
         rv_d         = 1'b0;
         hold_v_d     = 1'b0;
         peak_valid_d = 1'b0;
`ifdef MCA_SMOOTH_EN
         for (int k = 0; k < 7; k++) tap_d[k] = 16'd0;
         sum_d = 19'd0;
         s1_d  = 19'd0;
         s2_d  = 19'd0;
`else
         w1_d = 16'd0;
         w2_d = 16'd0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         addr_q       <= 10'd0;
         tgt_q        <= 32'd0;
         thr_q        <= 16'd0;
         event_cnt_q  <= 32'd0;
         peak_cnt_q   <= 11'd0;
         stop_pend_q  <= 1'b0;
         issue_done_q <= 1'b0;
         rv_q         <= 1'b0;
         ridx_q       <= 10'd0;
         hold_v_q     <= 1'b0;
         hold_q       <= 16'd0;
         peak_valid_q <= 1'b0;
         peak_chan_q  <= 10'd0;
`ifdef MCA_SMOOTH_EN
         for (int k = 0; k < 7; k++) tap_q[k] <= 16'd0;
         sum_q <= 19'd0;
         s1_q  <= 19'd0;
         s2_q  <= 19'd0;
`else
         w1_q <= 16'd0;
         w2_q <= 16'd0;
`endif
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         tgt_q        <= tgt_d;
         thr_q        <= thr_d;
         event_cnt_q  <= event_cnt_d;
         peak_cnt_q   <= peak_cnt_d;
         stop_pend_q  <= stop_pend_d;
         issue_done_q <= issue_done_d;
         rv_q         <= rv_d;
         ridx_q       <= ridx_d;
         hold_v_q     <= hold_v_d;
         hold_q       <= hold_d;
         peak_valid_q <= peak_valid_d;
         peak_chan_q  <= peak_chan_d;
`ifdef MCA_SMOOTH_EN
         for (int k = 0; k < 7; k++) tap_q[k] <= tap_d[k];
         sum_q <= sum_d;
         s1_q  <= s1_d;
         s2_q  <= s2_d;
`else
         w1_q <= w1_d;
         w2_q <= w2_d;
`endif
      end
   end

endmodule

// File: tb/tb_mca_acq_sequencer.sv
// tb/tb_mca_acq_sequencer.sv - directed self-checking bench for mca_acq_sequencer
module tb_mca_acq_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        stop;
   logic [31:0] target_events;
   logic [15:0] peak_thr;
   logic        ev_valid;
   logic [9:0]  ev_chan;
   logic        ev_ready;
   logic [9:0]  ram_addr;
   logic        ram_we;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
   logic        peak_valid;
   logic [9:0]  peak_chan;
   logic        peak_ready;
   logic        busy;
   logic        done;
   logic [31:0] event_cnt;
   logic [10:0] peak_cnt;

   mca_acq_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .target_events(target_events), .peak_thr(peak_thr),
      .ev_valid(ev_valid), .ev_chan(ev_chan), .ev_ready(ev_ready),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .peak_valid(peak_valid), .peak_chan(peak_chan), .peak_ready(peak_ready),
      .busy(busy), .done(done), .event_cnt(event_cnt), .peak_cnt(peak_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // histogram RAM model
   logic [15:0] mem [0:1023];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [83:0] all_outs;
   assign all_outs = {ram_addr, ram_we, ram_wdata, ev_ready, peak_valid, peak_chan,
                      busy, done, event_cnt, peak_cnt};

   // peak monitor: records handshakes, checks stability while stalled
   int       obs_q[$];
   int       exp_q[$];
   int       stall_cycles = 0;
   int       unstable = 0;
   logic     pv_prev = 1'b0;
   logic     pr_prev = 1'b0;
   logic [9:0] chan_prev = 10'd0;
   logic [9:0] addr_prev = 10'd0;
   always @(negedge clk) begin
      if (!rst) begin
         if (pv_prev && !pr_prev) begin
            stall_cycles++;
            if (peak_valid !== 1'b1 || peak_chan !== chan_prev || ram_addr !== addr_prev)
               unstable++;
         end
         if (peak_valid && peak_ready) obs_q.push_back(int'(peak_chan));
      end
      pv_prev   = peak_valid && !rst;
      pr_prev   = peak_ready;
      chan_prev = peak_chan;
      addr_prev = ram_addr;
   end

   int tests = 0;
   int fails = 0;
   int last_accept = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [31:0] tgt, input logic [15:0] thr);
      target_events = tgt;
      peak_thr      = thr;
      start         = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_clear();
      repeat (1024) @(posedge clk);
      #1;
   endtask

   task automatic send_event(input logic [9:0] ch, input logic with_stop);
      int n = 0;
      ev_valid = 1'b1;
      ev_chan  = ch;
      while (ev_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) check("ev_ready_timeout", ev_ready, 1'b1);
      stop        = with_stop;
      last_accept = cyc;
      @(posedge clk); #1;
      ev_valid = 1'b0;
      stop     = 1'b0;
   endtask

   task automatic issue_stop();
      int n = 0;
      while (ev_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      check("stop_to_scan", {busy, ev_ready, ram_we, ram_addr}, {1'b1, 1'b0, 1'b0, 10'd0});
   endtask

   task automatic wait_done();
      int n = 0;
      while (done !== 1'b1 && n < 4000) begin
         @(posedge clk); #1;
         n++;
      end
      check("done_reached", {done, busy, peak_valid}, 3'b100);
   endtask

   task automatic sb_check(input string tag);
      int o;
      int e;
      check({tag, "_count"}, obs_q.size(), exp_q.size());
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         check(tag, o, e);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time bound");
      $fatal(1, "timeout");
   end

   initial begin
      int bad;
      int gaps_bad;
      int prev;
      int sc0;
      int n;

      rst = 1'b1; start = 1'b0; stop = 1'b0; target_events = 0; peak_thr = 0;
      ev_valid = 1'b0; ev_chan = 0; peak_ready = 1'b1;
      for (int i = 0; i < 1024; i++) mem[i] = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", all_outs, 84'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_outputs", all_outs, 84'd0);

      // reset in the middle of a scan
      do_start(32'd1, 16'hFFFF);
      wait_clear();
      send_event(10'd20, 1'b0);
      repeat (100) @(posedge clk);
      #1;
      check("scan_busy", {busy, done, ev_ready}, 3'b100);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_scan", all_outs, 84'd0);
      rst = 1'b0;
      obs_q.delete();
      @(posedge clk); #1;

      // clear timing, then target stop after five events on channel 10
      do_start(32'd5, 16'd20);
      bad = 0;
      for (int k = 0; k < 1024; k++) begin
         if (ram_we !== 1'b1 || ram_addr !== k[9:0] || ram_wdata !== 16'd0 ||
             ev_ready !== 1'b0 || busy !== 1'b1 || event_cnt !== 32'd0)
            bad++;
         @(posedge clk); #1;
      end
      check("clear_writes", bad, 0);
      check("acq_ev_ready", {ev_ready, ram_we, busy}, 3'b101);
      gaps_bad = 0;
      prev = 0;
      for (int e = 0; e < 5; e++) begin
         send_event(10'd10, 1'b0);
         if (e > 0 && last_accept - prev != 2) gaps_bad++;
         prev = last_accept;
      end
      check("ev5_write", {ram_we, ram_addr, ram_wdata}, {1'b1, 10'd10, 16'd5});
      check("accept_gap", gaps_bad, 0);
      @(posedge clk); #1;
      check("scan_entry", {busy, ev_ready, ram_we, ram_addr}, {1'b1, 1'b0, 1'b0, 10'd0});
      check("event_cnt_5", event_cnt, 32'd5);
      wait_done();
      check("bin10", mem[10], 16'd5);
      check("peak_cnt_b", peak_cnt, 11'd0);
      sb_check("sb_target");

      // saturation
      do_start(32'd3, 16'hFFFF);
      wait_clear();
      mem[7] = 16'hFFFE;
      for (int e = 0; e < 3; e++) send_event(10'd7, 1'b0);
      wait_done();
      check("bin7_sat", mem[7], 16'hFFFF);
      check("event_cnt_sat", event_cnt, 32'd3);
      sb_check("sb_sat");

`ifndef MCA_SMOOTH_EN
      // raw peaks with a plateau
      do_start(32'd0, 16'd20);
      wait_clear();
      mem[99] = 16'd10; mem[100] = 16'd50; mem[101] = 16'd10;
      mem[500] = 16'd40; mem[501] = 16'd40;
      exp_q.push_back(100);
      issue_stop();
      wait_done();
      check("peak_cnt_raw", peak_cnt, 11'd1);
      check("event_cnt_raw", event_cnt, 32'd0);
      sb_check("sb_raw");

      // backpressure: three isolated peaks, each held off for 20 cycles
      do_start(32'd0, 16'd20);
      wait_clear();
      mem[200] = 16'd30; mem[400] = 16'd31; mem[600] = 16'd32;
      exp_q.push_back(200); exp_q.push_back(400); exp_q.push_back(600);
      peak_ready = 1'b0;
      sc0 = stall_cycles;
      issue_stop();
      for (int p = 0; p < 3; p++) begin
         n = 0;
         while (peak_valid !== 1'b1 && n < 3000) begin
            @(posedge clk); #1;
            n++;
         end
         check("bp_peak_seen", peak_valid, 1'b1);
         repeat (20) @(posedge clk);
         #1;
         peak_ready = 1'b1;
         @(posedge clk); #1;
         peak_ready = 1'b0;
      end
      peak_ready = 1'b1;
      wait_done();
      check("bp_unstable", unstable, 0);
      check("bp_stalled", (stall_cycles - sc0) >= 60, 1'b1);
      check("peak_cnt_bp", peak_cnt, 11'd3);
      sb_check("sb_bp");
`endif

      // bin 3 spike, run-until-stop with stop in the 4th accept cycle
      do_start(32'd0, 16'd100);
      wait_clear();
      mem[3] = 16'd1000;
`ifndef MCA_SMOOTH_EN
      exp_q.push_back(3);
`endif
      for (int e = 0; e < 3; e++) send_event(10'd900, 1'b0);
      send_event(10'd900, 1'b1);
      check("stop_write", {ram_we, ram_addr, ram_wdata}, {1'b1, 10'd900, 16'd4});
      @(posedge clk); #1;
      check("stop_scan", {busy, ev_ready, ram_we, ram_addr}, {1'b1, 1'b0, 1'b0, 10'd0});
      wait_done();
      check("event_cnt_stop", event_cnt, 32'd4);
      check("bin900", mem[900], 16'd4);
      check("peak_cnt_spike", peak_cnt, 11'(exp_q.size()));
      sb_check("sb_spike");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
